// File: rtl/udp_pkt_rx.sv
// udp_pkt_rx: GMII receiver that filters Ethernet/IPv4/UDP frames for this node and streams the UDP payload.
// Define UDP_RX_CRC_CHECK_EN to additionally require a correct Ethernet FCS before pkt_ok is raised.
module udp_pkt_rx #(
   parameter logic [47:0] LOCAL_MAC  = 48'h000A3501FEC0,
   parameter logic [31:0] LOCAL_IP   = 32'hC0A80002,
   parameter logic [15:0] LOCAL_PORT = 16'd1234
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_dv,
   input  logic       rx_er,
   input  logic [7:0] rx_d,
   output logic [7:0] out_data,
   output logic       out_valid,
   output logic       out_sop,
   output logic       out_eop,
   output logic       pkt_done,
   output logic       pkt_ok
);

   typedef enum logic [2:0] {
      IDLE, PREAMBLE, ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, TAIL, DROP
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [15:0] pay_cnt_q, pay_cnt_d;
   logic [2:0]  tail_cnt_q, tail_cnt_d;
   logic [7:0]  len_hi_q, len_hi_d;
   logic        mac_loc_q, mac_loc_d;
   logic        mac_bc_q, mac_bc_d;
   logic        first_q, first_d;
   logic        err_q, err_d;
   logic        armed_q, armed_d;
   logic [7:0]  out_data_q, out_data_d;
   logic        out_valid_q, out_valid_d;
   logic        out_sop_q, out_sop_d;
   logic        out_eop_q, out_eop_d;
   logic        pkt_done_q, pkt_done_d;
   logic        pkt_ok_q, pkt_ok_d;
   logic        crc_good;
   logic [2:0]  mac_idx;
   logic [1:0]  ip_idx;
   logic [15:0] udp_len;

   // Address fields arrive most-significant byte first.
   assign mac_idx = 3'd5 - cnt_q[2:0];
   assign ip_idx  = 2'd3 - cnt_q[1:0];
   assign udp_len = {len_hi_q, rx_d};

   // NOTE: every variable gets a default before the case so no latch can be inferred.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pay_cnt_d   = pay_cnt_q;
      tail_cnt_d  = tail_cnt_q;
      len_hi_d    = len_hi_q;
      mac_loc_d   = mac_loc_q;
      mac_bc_d    = mac_bc_q;
      first_d     = first_q;
      err_d       = err_q;
      out_data_d  = out_data_q;
      out_valid_d = 1'b0;
      out_sop_d   = 1'b0;
      out_eop_d   = 1'b0;
      pkt_done_d  = 1'b0;
      pkt_ok_d    = 1'b0;
      // A frame may only start after rx_dv has been seen low, so a reset release mid-frame drops it.
      armed_d     = armed_q | ~rx_dv;

      case (state_q)
         IDLE: begin
            if (rx_dv) begin
               if (armed_q && !rx_er && rx_d == 8'h55) begin
                  state_d = PREAMBLE;
                  cnt_d   = 5'd1;
               end else begin
                  state_d = DROP;
               end
            end
         end
         PREAMBLE: begin
            if (!rx_dv)                              state_d = IDLE;
            else if (rx_er)                          state_d = DROP;
            else if (rx_d == 8'hD5) begin
               state_d   = ETH_HDR;
               cnt_d     = '0;
               mac_loc_d = 1'b1;
               mac_bc_d  = 1'b1;
               err_d     = 1'b0;
            end
            else if (rx_d == 8'h55 && cnt_q != 5'd7) cnt_d = cnt_q + 5'd1;
            else                                     state_d = DROP;
         end
         ETH_HDR: begin
            if (!rx_dv)     state_d = IDLE;
            else if (rx_er) state_d = DROP;
            else begin
               cnt_d = cnt_q + 5'd1;
               if (cnt_q < 5'd6) begin
                  mac_loc_d = mac_loc_q & (rx_d == LOCAL_MAC[{mac_idx, 3'b000} +: 8]);
                  mac_bc_d  = mac_bc_q & (rx_d == 8'hFF);
                  if (!mac_loc_d && !mac_bc_d) state_d = DROP;
               end else if (cnt_q == 5'd12) begin
                  if (rx_d != 8'h08) state_d = DROP;
               end else if (cnt_q == 5'd13) begin
                  state_d = (rx_d == 8'h00) ? IP_HDR : DROP;
                  cnt_d   = '0;
               end
            end
         end
         IP_HDR: begin
            if (!rx_dv)     state_d = IDLE;
            else if (rx_er) state_d = DROP;
            else begin
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == 5'd0 && rx_d != 8'h45) state_d = DROP;
               if (cnt_q == 5'd9 && rx_d != 8'h11) state_d = DROP;
               if (cnt_q >= 5'd16 && rx_d != LOCAL_IP[{ip_idx, 3'b000} +: 8]) state_d = DROP;
               else if (cnt_q == 5'd19) begin
                  state_d = UDP_HDR;
                  cnt_d   = '0;
               end
            end
         end
         UDP_HDR: begin
            if (!rx_dv)     state_d = IDLE;
            else if (rx_er) state_d = DROP;
            else begin
               cnt_d = cnt_q + 5'd1;
               case (cnt_q)
                  5'd2: if (rx_d != LOCAL_PORT[15:8]) state_d = DROP;
                  5'd3: if (rx_d != LOCAL_PORT[7:0])  state_d = DROP;
                  5'd4: len_hi_d = rx_d;
                  5'd5: begin
                     if (udp_len < 16'd8) state_d = DROP;
                     else                 pay_cnt_d = udp_len - 16'd8;
                  end
                  5'd7: begin
                     first_d    = 1'b1;
                     tail_cnt_d = '0;
                     state_d    = (pay_cnt_q == 16'd0) ? TAIL : PAYLOAD;
                  end
                  default: ;
               endcase
            end
         end
         PAYLOAD: begin
            if (!rx_dv) begin
               pkt_done_d = 1'b1;
               state_d    = IDLE;
            end else begin
               out_valid_d = 1'b1;
               out_data_d  = rx_d;
               out_sop_d   = first_q;
               out_eop_d   = (pay_cnt_q == 16'd1);
               first_d     = 1'b0;
               err_d       = err_q | rx_er;
               pay_cnt_d   = pay_cnt_q - 16'd1;
               if (pay_cnt_q == 16'd1) state_d = TAIL;
            end
         end
         TAIL: begin
            if (!rx_dv) begin
               pkt_done_d = 1'b1;
               pkt_ok_d   = !err_q && tail_cnt_q >= 3'd4 && crc_good;
               state_d    = IDLE;
            end else begin
               err_d = err_q | rx_er;
               if (tail_cnt_q != 3'd4) tail_cnt_d = tail_cnt_q + 3'd1;
            end
         end
         DROP: begin
            if (!rx_dv) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         pay_cnt_q   <= '0;
         tail_cnt_q  <= '0;
         len_hi_q    <= '0;
         mac_loc_q   <= 1'b0;
         mac_bc_q    <= 1'b0;
         first_q     <= 1'b0;
         err_q       <= 1'b0;
         armed_q     <= 1'b0;
         out_data_q  <= 8'h00;
         out_valid_q <= 1'b0;
         out_sop_q   <= 1'b0;
         out_eop_q   <= 1'b0;
         pkt_done_q  <= 1'b0;
         pkt_ok_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pay_cnt_q   <= pay_cnt_d;
         tail_cnt_q  <= tail_cnt_d;
         len_hi_q    <= len_hi_d;
         mac_loc_q   <= mac_loc_d;
         mac_bc_q    <= mac_bc_d;
         first_q     <= first_d;
         err_q       <= err_d;
         armed_q     <= armed_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_sop_q   <= out_sop_d;
         out_eop_q   <= out_eop_d;
         pkt_done_q  <= pkt_done_d;
         pkt_ok_q    <= pkt_ok_d;
      end
   end

`ifdef UDP_RX_CRC_CHECK_EN
   localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

   logic [31:0] crc_q, crc_d, crc_rev;

   function automatic logic [31:0] crc_next(input logic [31:0] crc, input logic [7:0] d);
      logic [31:0] c;
      c = crc ^ {24'h0, d};
      for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      return c;
   endfunction

   always_comb begin
      crc_d = crc_q;
      if (state_q == PREAMBLE) crc_d = '1;
      else if (rx_dv && state_q inside {ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, TAIL})
         crc_d = crc_next(crc_q, rx_d);
      // The LSB-first register holds the residue bit-reversed.
      for (int i = 0; i < 32; i++) crc_rev[i] = crc_q[31-i];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) crc_q <= '0;
      else        crc_q <= crc_d;
   end

   assign crc_good = (crc_rev == CRC_RESIDUE);
`else
   assign crc_good = 1'b1;
`endif

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign out_sop   = out_sop_q;
   assign out_eop   = out_eop_q;
   assign pkt_done  = pkt_done_q;
   assign pkt_ok    = pkt_ok_q;

endmodule

// File: tb/tb_udp_pkt_rx.sv
// tb_udp_pkt_rx: directed frames against udp_pkt_rx; a negedge monitor logs payload beats and pkt_done results.
// Define UDP_RX_CRC_CHECK_EN here as for the DUT to expect the FCS-checking behaviour.
module tb_udp_pkt_rx;

   localparam logic [47:0] LOCAL_MAC  = 48'h000A3501FEC0;
   localparam logic [31:0] LOCAL_IP   = 32'hC0A80002;
   localparam logic [15:0] LOCAL_PORT = 16'd1234;
   localparam logic [47:0] BCAST_MAC  = 48'hFFFFFFFFFFFF;

   logic       clk = 1'b0;
   logic       rst_n, rx_dv, rx_er;
   logic [7:0] rx_d;
   logic [7:0] out_data;
   logic       out_valid, out_sop, out_eop, pkt_done, pkt_ok;

   udp_pkt_rx #(
      .LOCAL_MAC (LOCAL_MAC),
      .LOCAL_IP  (LOCAL_IP),
      .LOCAL_PORT(LOCAL_PORT)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rx_dv    (rx_dv),
      .rx_er    (rx_er),
      .rx_d     (rx_d),
      .out_data (out_data),
      .out_valid(out_valid),
      .out_sop  (out_sop),
      .out_eop  (out_eop),
      .pkt_done (pkt_done),
      .pkt_ok   (pkt_ok)
   );

   always #4 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Monitor: append-only logs of payload beats and frame results.
   logic [7:0] beat_data [0:63];
   logic       beat_sop  [0:63];
   logic       beat_eop  [0:63];
   logic       ok_log    [0:15];
   int         beat_cnt = 0;
   int         done_cnt = 0;

   always @(negedge clk) begin
      if (out_valid && beat_cnt < 64) begin
         beat_data[beat_cnt] <= out_data;
         beat_sop[beat_cnt]  <= out_sop;
         beat_eop[beat_cnt]  <= out_eop;
         beat_cnt            <= beat_cnt + 1;
      end
      if (pkt_done && done_cnt < 16) begin
         ok_log[done_cnt] <= pkt_ok;
         done_cnt         <= done_cnt + 1;
      end
   end

   // Reference CRC-32, evaluated one bit at a time.
   function automatic logic [31:0] crc_ref(input logic [31:0] crc, input logic [7:0] d);
      logic [31:0] r;
      logic        fb;
      r = crc;
      for (int b = 0; b < 8; b++) begin
         fb = r[0] ^ d[b];
         r  = r >> 1;
         if (fb) r = r ^ 32'hEDB88320;
      end
      return r;
   endfunction

   logic [7:0] frm[$];

   task automatic build(input int n_pre, input logic [47:0] mac, input logic [15:0] port, input int n_pay);
      logic [31:0] crc;
      logic [15:0] ip_len, udp_len;
      ip_len  = 16'(28 + n_pay);
      udp_len = 16'(8 + n_pay);
      frm.delete();
      repeat (n_pre) frm.push_back(8'h55);
      frm.push_back(8'hD5);
      for (int i = 0; i < 6; i++) frm.push_back(mac[47-8*i -: 8]);
      frm.push_back(8'h02); frm.push_back(8'h00); frm.push_back(8'h00);
      frm.push_back(8'h00); frm.push_back(8'h00); frm.push_back(8'h01);
      frm.push_back(8'h08); frm.push_back(8'h00);
      frm.push_back(8'h45); frm.push_back(8'h00);
      frm.push_back(ip_len[15:8]); frm.push_back(ip_len[7:0]);
      frm.push_back(8'h00); frm.push_back(8'h00); frm.push_back(8'h40); frm.push_back(8'h00);
      frm.push_back(8'h40); frm.push_back(8'h11); frm.push_back(8'h00); frm.push_back(8'h00);
      frm.push_back(8'hC0); frm.push_back(8'hA8); frm.push_back(8'h00); frm.push_back(8'h01);
      for (int i = 0; i < 4; i++) frm.push_back(LOCAL_IP[31-8*i -: 8]);
      frm.push_back(8'h1F); frm.push_back(8'h90);
      frm.push_back(port[15:8]); frm.push_back(port[7:0]);
      frm.push_back(udp_len[15:8]); frm.push_back(udp_len[7:0]);
      frm.push_back(8'h00); frm.push_back(8'h00);
      for (int i = 0; i < n_pay; i++) frm.push_back(8'(i + 1));
      while (frm.size() < n_pre + 1 + 60) frm.push_back(8'h00);
      crc = 32'hFFFFFFFF;
      for (int i = n_pre + 1; i < frm.size(); i++) crc = crc_ref(crc, frm[i]);
      crc = ~crc;
      for (int i = 0; i < 4; i++) frm.push_back(crc[8*i +: 8]);
   endtask

   task automatic send(input int n_bytes, input int er_at, input int rst_from, input int rst_to);
      int n;
      n = (n_bytes < 0) ? frm.size() : n_bytes;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         rx_dv = 1'b1;
         rx_d  = frm[i];
         rx_er = (i == er_at);
         if (i == rst_from) rst_n = 1'b0;
         if (i == rst_to)   rst_n = 1'b1;
      end
      @(posedge clk); #1;
      rx_dv = 1'b0;
      rx_er = 1'b0;
      rx_d  = 8'h00;
   endtask

   // Payload bytes are 01,02,03,04 per frame, so beat k carries (k%4)+1.
   task automatic expect_frames(input string tag, input int b0, input int d0,
                                input int n_beats, input int n_done, input logic ok);
      int got_beats, got_done;
      got_beats = beat_cnt - b0;
      got_done  = done_cnt - d0;
      check({tag, "_beats"}, 32'(got_beats), 32'(n_beats));
      check({tag, "_done"},  32'(got_done),  32'(n_done));
      for (int k = 0; k < n_beats && k < got_beats; k++) begin
         check($sformatf("%s_data%0d", tag, k), 32'(beat_data[b0+k]), 32'((k % 4) + 1));
         check($sformatf("%s_sop%0d", tag, k),  32'(beat_sop[b0+k]),  32'(k % 4 == 0));
         check($sformatf("%s_eop%0d", tag, k),  32'(beat_eop[b0+k]),  32'(k % 4 == 3));
      end
      for (int j = 0; j < n_done && j < got_done; j++)
         check($sformatf("%s_ok%0d", tag, j), 32'(ok_log[d0+j]), 32'(ok));
   endtask

   task automatic run(input string tag, input int n_bytes, input int er_at,
                      input int n_beats, input int n_done, input logic ok);
      int b0, d0;
      b0 = beat_cnt;
      d0 = done_cnt;
      send(n_bytes, er_at, -1, -1);
      repeat (4) @(posedge clk);
      expect_frames(tag, b0, d0, n_beats, n_done, ok);
   endtask

   initial begin
      int   b0, d0;
      logic crc_flip_ok;
      rst_n = 1'b0;
      rx_dv = 1'b0;
      rx_er = 1'b0;
      rx_d  = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_data",  32'(out_data),  32'h00);
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_out_sop",   32'(out_sop),   32'h0);
      check("rst_out_eop",   32'(out_eop),   32'h0);
      check("rst_pkt_done",  32'(pkt_done),  32'h0);
      check("rst_pkt_ok",    32'(pkt_ok),    32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);

      build(7, LOCAL_MAC, LOCAL_PORT, 4);
      run("good", -1, -1, 4, 1, 1'b1);

      build(7, LOCAL_MAC, LOCAL_PORT + 16'd1, 4);
      run("bad_port", -1, -1, 0, 0, 1'b0);

      build(7, LOCAL_MAC, LOCAL_PORT, 4);
      run("rx_er_pay", -1, 51, 4, 1, 1'b0);

      build(7, LOCAL_MAC, LOCAL_PORT, 4);
      run("trunc", 52, -1, 2, 1, 1'b0);

`ifdef UDP_RX_CRC_CHECK_EN
      crc_flip_ok = 1'b0;
`else
      crc_flip_ok = 1'b1;
`endif
      build(7, LOCAL_MAC, LOCAL_PORT, 4);
      frm[frm.size()-1] = frm[frm.size()-1] ^ 8'h01;
      run("fcs_flip", -1, -1, 4, 1, crc_flip_ok);

      build(7, LOCAL_MAC, LOCAL_PORT, 0);
      run("len8", -1, -1, 0, 1, 1'b1);

      build(8, LOCAL_MAC, LOCAL_PORT, 4);
      run("pre8", -1, -1, 0, 0, 1'b0);

      build(1, BCAST_MAC, LOCAL_PORT, 4);
      run("pre1_bcast", -1, -1, 4, 1, 1'b1);

      build(7, LOCAL_MAC, LOCAL_PORT, 4);
      run("ip_short", 30, -1, 0, 0, 1'b0);

      // Reset pulsed during the preamble: the rest of that frame is discarded.
      b0 = beat_cnt;
      d0 = done_cnt;
      build(7, LOCAL_MAC, LOCAL_PORT, 4);
      send(-1, -1, 1, 3);
      repeat (4) @(posedge clk);
      expect_frames("mid_rst", b0, d0, 0, 0, 1'b0);

      // Back-to-back with a 12-cycle gap, second frame broadcast.
      b0 = beat_cnt;
      d0 = done_cnt;
      build(7, LOCAL_MAC, LOCAL_PORT, 4);
      send(-1, -1, -1, -1);
      repeat (11) @(posedge clk);
      build(7, BCAST_MAC, LOCAL_PORT, 4);
      send(-1, -1, -1, -1);
      repeat (4) @(posedge clk);
      expect_frames("b2b_gap12", b0, d0, 8, 2, 1'b1);

      // Minimum gap: next frame starts while pkt_done of the previous is high.
      b0 = beat_cnt;
      d0 = done_cnt;
      build(7, LOCAL_MAC, LOCAL_PORT, 4);
      send(-1, -1, -1, -1);
      send(-1, -1, -1, -1);
      repeat (4) @(posedge clk);
      expect_frames("b2b_gap1", b0, d0, 8, 2, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
